// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a one-entry holding buffer.
// A byte offered while a frame is in flight is parked in the buffer and
// launched on the edge that completes the current stop bit, so back-to-back
// frames run with no idle gap on the line.
module uart_tx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  // A 1-cycle bit time would give a zero-width counter; keep one bit minimum.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state,     state_nxt;
  logic [CNT_W-1:0] clk_cnt,   clk_cnt_nxt;
  logic [2:0]       bit_cnt,   bit_cnt_nxt;
  logic [7:0]       shift_reg, shift_nxt;
  logic [7:0]       buf_data,  buf_data_nxt;
  logic             buf_full,  buf_full_nxt;
  logic             tx_reg,    tx_nxt;

  logic accept;
  logic bit_done;

  // Handshake and bit-boundary qualifiers; ready is purely a flop decode.
  always_comb begin
    accept   = data_valid_i & ~buf_full;
    bit_done = (clk_cnt == CNT_LAST);
  end

  // Next-state, counter, shift-register and holding-buffer logic.
  always_comb begin
    state_nxt    = state;
    clk_cnt_nxt  = clk_cnt + CNT_W'(1);
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift_reg;
    buf_data_nxt = buf_data;
    buf_full_nxt = buf_full;

    case (state)
      IDLE: begin
        clk_cnt_nxt = '0;
        bit_cnt_nxt = '0;
        if (accept) begin
          state_nxt = START;
          shift_nxt = data_i;
        end
      end

      START: begin
        if (bit_done) begin
          state_nxt   = DATA;
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
        end
        if (accept) begin
          buf_data_nxt = data_i;
          buf_full_nxt = 1'b1;
        end
      end

      DATA: begin
        if (bit_done) begin
          clk_cnt_nxt = '0;
          // 3-bit counter wraps 7->0 on the way into STOP.
          bit_cnt_nxt = bit_cnt + 3'd1;
          shift_nxt   = {1'b0, shift_reg[7:1]};
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
          end
        end
        if (accept) begin
          buf_data_nxt = data_i;
          buf_full_nxt = 1'b1;
        end
      end

      STOP: begin
        if (bit_done) begin
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          if (buf_full) begin
            // Drain the parked byte straight into a new start bit.
            state_nxt    = START;
            shift_nxt    = buf_data;
            buf_full_nxt = 1'b0;
            buf_data_nxt = '0;
          end else if (accept) begin
            state_nxt = START;
            shift_nxt = data_i;
          end else begin
            state_nxt = IDLE;
          end
        end else if (accept) begin
          buf_data_nxt = data_i;
          buf_full_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt   = IDLE;
        clk_cnt_nxt = '0;
        bit_cnt_nxt = '0;
      end
    endcase
  end

  // Line level for the coming cycle, derived from where the FSM is heading
  // so that tx_o can be a plain flop with no output decode.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      IDLE:    tx_nxt = 1'b1;
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      STOP:    tx_nxt = 1'b1;
      default: tx_nxt = 1'b1;
    endcase
  end

  // State register; reset aborts any frame and empties the buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      buf_data  <= '0;
      buf_full  <= 1'b0;
      tx_reg    <= 1'b1;
    end else begin
      state     <= state_nxt;
      clk_cnt   <= clk_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_reg <= shift_nxt;
      buf_data  <= buf_data_nxt;
      buf_full  <= buf_full_nxt;
      tx_reg    <= tx_nxt;
    end
  end

  // Status outputs decoded from registered state only.
  always_comb begin
    tx_o    = tx_reg;
    ready_o = ~buf_full;
    busy_o  = (state != IDLE) | buf_full;
  end

endmodule
